// File: rtl/ahblite_filter_ctrl.sv
// AHB-Lite control/status block for NCH filter engines.
// Holds per-channel enable and mode, issues start pulses, tracks busy and
// sticky done flags, counts completions and raises a level interrupt.
module ahblite_filter_ctrl #(
   parameter int NCH    = 4,
   parameter int MODE_W = 2
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [3:0]            HPROT,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [NCH-1:0]        ch_en,
   output logic [NCH*MODE_W-1:0] ch_mode,
   output logic [NCH-1:0]        ch_start,
   input  logic [NCH-1:0]        ch_done,
   output logic                  irq
);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_MODE   = 3'd1;
   localparam logic [2:0] OFF_START  = 3'd2;
   localparam logic [2:0] OFF_STATUS = 3'd3;
   localparam logic [2:0] OFF_IRQEN  = 3'd4;
   localparam logic [2:0] OFF_CNT    = 3'd5;

   logic [2:0]            addr_q, addr_d;
   logic                  write_q, write_d;
   logic [NCH-1:0]        ctrl_q, ctrl_d;
   logic [NCH*MODE_W-1:0] mode_q, mode_d;
   logic [NCH-1:0]        busy_q, busy_d;
   logic [NCH-1:0]        done_q, done_d;
   logic [NCH-1:0]        irq_en_q, irq_en_d;
   logic [15:0]           done_cnt_q, done_cnt_d;
   logic [NCH-1:0]        ch_start_q, ch_start_d;
   logic                  irq_q, irq_d;

   logic                  sel;
   logic                  wr;
   logic [NCH-1:0]        start_req;
   logic [NCH-1:0]        abort;
   logic [NCH-1:0]        w1c;
   logic [NCH-1:0]        done_acc;
   logic [NCH-1:0]        start_iss;
   logic [15:0]           pop;

   // Transfer size, protection and address bits outside the map are don't-cares.
   logic unused_inputs;
   assign unused_inputs = ^{HSIZE, HPROT, HADDR, HTRANS[0], HWDATA};

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign ch_en     = ctrl_q;
   assign ch_mode   = mode_q;
   assign ch_start  = ch_start_q;
   assign irq       = irq_q;

   // Next-state: bus pipeline, register writes, channel start/done/abort and completion count.
   always_comb begin
      sel        = HSEL & HTRANS[1] & HREADY;
      wr         = write_q & HREADY;
      addr_d     = sel ? HADDR[4:2] : addr_q;
      write_d    = HREADY ? (sel & HWRITE) : write_q;
      ctrl_d     = ctrl_q;
      mode_d     = mode_q;
      irq_en_d   = irq_en_q;
      start_req  = '0;
      abort      = '0;
      w1c        = '0;
      if (wr) begin
         case (addr_q)
            OFF_CTRL: begin
               ctrl_d = HWDATA[NCH-1:0];
               abort  = busy_q & ~HWDATA[NCH-1:0];
            end
            OFF_MODE:   mode_d    = HWDATA[NCH*MODE_W-1:0];
            OFF_START:  start_req = HWDATA[NCH-1:0];
            OFF_STATUS: w1c       = HWDATA[8 +: NCH];
            OFF_IRQEN:  irq_en_d  = HWDATA[NCH-1:0];
            default: ;
         endcase
      end
      done_acc  = ch_done & busy_q & ~abort;
      start_iss = start_req & ctrl_q & ~busy_q;
      busy_d    = (busy_q & ~done_acc & ~abort) | start_iss;
      done_d    = (done_q & ~w1c) | done_acc;
      pop       = '0;
      for (int i = 0; i < NCH; i++) begin
         pop = pop + 16'(done_acc[i]);
      end
      done_cnt_d = (wr && (addr_q == OFF_CNT)) ? pop : (done_cnt_q + pop);
      ch_start_d = start_iss;
      irq_d      = |(done_q & irq_en_q);
   end

   // State register with synchronous reset.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         addr_q     <= '0;
         write_q    <= 1'b0;
         ctrl_q     <= '0;
         mode_q     <= '0;
         busy_q     <= '0;
         done_q     <= '0;
         irq_en_q   <= '0;
         done_cnt_q <= '0;
         ch_start_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         write_q    <= write_d;
         ctrl_q     <= ctrl_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         irq_en_q   <= irq_en_d;
         done_cnt_q <= done_cnt_d;
         ch_start_q <= ch_start_d;
         irq_q      <= irq_d;
      end
   end

   // Read mux driven by the registered data-phase address.
   always_comb begin
      HRDATA = '0;
      case (addr_q)
         OFF_CTRL:   HRDATA[NCH-1:0]        = ctrl_q;
         OFF_MODE:   HRDATA[NCH*MODE_W-1:0] = mode_q;
         OFF_STATUS: begin
            HRDATA[NCH-1:0]  = busy_q;
            HRDATA[8 +: NCH] = done_q;
         end
         OFF_IRQEN:  HRDATA[NCH-1:0]        = irq_en_q;
         OFF_CNT:    HRDATA[15:0]           = done_cnt_q;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahblite_filter_ctrl.sv
// Self-checking bench for ahblite_filter_ctrl: directed scenarios plus random
// traffic, compared every cycle against a per-channel behavioural model.
module tb_ahblite_filter_ctrl;

   logic        HCLK, HRESET, HSEL, HWRITE, HREADY;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic        HREADYOUT, HRESP, irq;
   logic [31:0] HRDATA;
   logic [3:0]  ch_en, ch_start, ch_done;
   logic [7:0]  ch_mode;

   int checks = 0;
   int errors = 0;

   // Behavioural model: one entry per channel, counter kept as a plain integer.
   bit m_en[4], m_busy[4], m_done[4], m_irqen[4], m_start[4];
   int m_mode[4];
   int m_cnt;
   bit m_irq, m_write;
   int m_addr;

   ahblite_filter_ctrl #(.NCH(4), .MODE_W(2)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .ch_en(ch_en),
      .ch_mode(ch_mode), .ch_start(ch_start), .ch_done(ch_done), .irq(irq)
   );

   // Free-running clock.
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] modelRead(input int off);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         case (off)
            0: r[i] = m_en[i];
            1: r = r | (32'(m_mode[i]) << (2 * i));
            3: begin r[i] = m_busy[i]; r[8 + i] = m_done[i]; end
            4: r[i] = m_irqen[i];
            default: ;
         endcase
      end
      if (off == 5) r = 32'(m_cnt);
      return r;
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   function automatic void modelEdge();
      bit wr, ab, acc, st, irqNext;
      bit nb[4], nd[4];
      int n, off;
      if (HRESET) begin
         for (int i = 0; i < 4; i++) begin
            m_en[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_irqen[i] = 0; m_start[i] = 0; m_mode[i] = 0;
         end
         m_cnt = 0; m_irq = 0; m_write = 0; m_addr = 0;
         return;
      end
      wr = m_write && HREADY;
      off = m_addr;
      irqNext = 0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (m_done[i] && m_irqen[i]) irqNext = 1;
         ab  = wr && off == 0 && !HWDATA[i] && m_busy[i];
         acc = ch_done[i] && m_busy[i] && !ab;
         st  = wr && off == 2 && HWDATA[i] && m_en[i] && !m_busy[i];
         if (acc) n++;
         m_start[i] = st;
         nb[i] = st || (m_busy[i] && !acc && !ab);
         nd[i] = acc || (m_done[i] && !(wr && off == 3 && HWDATA[8 + i]));
      end
      for (int i = 0; i < 4; i++) begin
         m_busy[i] = nb[i];
         m_done[i] = nd[i];
         if (wr && off == 0) m_en[i] = HWDATA[i];
         if (wr && off == 1) m_mode[i] = int'((HWDATA >> (2 * i)) & 32'h3);
         if (wr && off == 4) m_irqen[i] = HWDATA[i];
      end
      m_cnt = (wr && off == 5) ? n : (m_cnt + n) % 65536;
      m_irq = irqNext;
      if (HREADY) begin
         if (HSEL && HTRANS[1]) begin
            m_addr  = int'(HADDR[4:2]);
            m_write = HWRITE;
         end else begin
            m_write = 0;
         end
      end
   endfunction

   task automatic checkAll();
      logic [3:0] expEn, expStart;
      logic [7:0] expMode;
      for (int i = 0; i < 4; i++) begin
         expEn[i] = m_en[i];
         expStart[i] = m_start[i];
         expMode[2 * i +: 2] = 2'(m_mode[i]);
      end
      checkOutput("ch_en", 32'(ch_en), 32'(expEn));
      checkOutput("ch_mode", 32'(ch_mode), 32'(expMode));
      checkOutput("ch_start", 32'(ch_start), 32'(expStart));
      checkOutput("irq", 32'(irq), 32'(m_irq));
      checkOutput("hrdata", HRDATA, modelRead(m_addr));
      checkOutput("hreadyout", 32'(HREADYOUT), 32'h1);
      checkOutput("hresp", 32'(HRESP), 32'h0);
   endtask

   task automatic tick();
      modelEdge();
      @(posedge HCLK);
      #1;
      checkAll();
   endtask

   task automatic idle();
      HSEL   = 1'($urandom);
      HTRANS = {1'b0, 1'($urandom)};
      HWRITE = 1'($urandom);
      HADDR  = $urandom;
      HWDATA = $urandom;
      HSIZE  = 3'($urandom);
      HPROT  = 4'($urandom);
   endtask

   task automatic addrPhase(input logic [4:0] off, input logic wrFlag);
      HSEL   = 1'b1;
      HTRANS = {1'b1, 1'($urandom)};
      HWRITE = wrFlag;
      HADDR  = {27'($urandom), off[4:2], 2'($urandom)};
      HSIZE  = 3'($urandom);
      HPROT  = 4'($urandom);
      HWDATA = $urandom;
   endtask

   task automatic writeReg(input logic [4:0] off, input logic [31:0] data, input logic [3:0] doneMask);
      addrPhase(off, 1'b1);
      ch_done = '0;
      tick();
      idle();
      HWDATA  = data;
      ch_done = doneMask;
      tick();
      ch_done = '0;
   endtask

   task automatic readReg(input logic [4:0] off, input logic [31:0] expected, input string tag);
      addrPhase(off, 1'b0);
      ch_done = '0;
      tick();
      idle();
      checkOutput(tag, HRDATA, expected);
   endtask

   task automatic pulseDone(input logic [3:0] mask);
      idle();
      ch_done = mask;
      tick();
      ch_done = '0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         idle();
         tick();
      end
   endtask

   // One random bus/engine event.
   task automatic applyStimulus();
      int r;
      logic [3:0] dm;
      r  = $urandom_range(0, 9);
      dm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if (r < 5) begin
         writeReg({3'($urandom), 2'b00}, $urandom, dm);
      end else if (r < 7) begin
         writeReg(5'h08, 32'($urandom_range(0, 15)), dm);
      end else if (r < 9) begin
         addrPhase({3'($urandom), 2'b00}, 1'b0);
         ch_done = dm;
         tick();
         ch_done = '0;
      end else if ($urandom_range(0, 9) == 0) begin
         idle();
         HRESET = 1'b1;
         tick();
         HRESET = 1'b0;
      end else begin
         pulseDone(4'($urandom));
      end
   endtask

   // Directed scenarios followed by random traffic.
   initial begin
      HREADY  = 1'b1;
      HRESET  = 1'b1;
      ch_done = '0;
      idle();
      tick();
      tick();
      HRESET = 1'b0;
      checkOutput("reset_status", HRDATA, 32'h0);

      // Single run on channel 0
      writeReg(5'h00, 32'h1, 4'h0);
      writeReg(5'h08, 32'h1, 4'h0);
      checkOutput("start_pulse", 32'(ch_start), 32'h1);
      readReg(5'h0C, 32'h001, "status_busy");
      checkOutput("start_one_cycle", 32'(ch_start), 32'h0);
      idleCycles(3);
      pulseDone(4'h1);
      readReg(5'h0C, 32'h100, "status_done");
      readReg(5'h14, 32'h1, "cnt_one");

      // Start while busy, and start coinciding with done
      writeReg(5'h08, 32'h1, 4'h0);
      checkOutput("restart_pulse", 32'(ch_start), 32'h1);
      writeReg(5'h08, 32'h1, 4'h0);
      checkOutput("busy_no_start", 32'(ch_start), 32'h0);
      writeReg(5'h08, 32'h1, 4'h1);
      checkOutput("start_with_done", 32'(ch_start), 32'h0);
      readReg(5'h0C, 32'h100, "status_after_race");

      // Interrupt on channel 1
      writeReg(5'h0C, 32'h100, 4'h0);
      writeReg(5'h00, 32'h3, 4'h0);
      writeReg(5'h10, 32'h2, 4'h0);
      writeReg(5'h08, 32'h2, 4'h0);
      pulseDone(4'h2);
      checkOutput("irq_delay", 32'(irq), 32'h0);
      idleCycles(1);
      checkOutput("irq_set", 32'(irq), 32'h1);
      writeReg(5'h0C, 32'h200, 4'h0);
      idleCycles(1);
      checkOutput("irq_clear", 32'(irq), 32'h0);
      writeReg(5'h08, 32'h2, 4'h0);
      writeReg(5'h0C, 32'h200, 4'h2);
      readReg(5'h0C, 32'h200, "set_wins_w1c");
      checkOutput("irq_set_wins", 32'(irq), 32'h1);

      // Counter: multi-completion, wrap, clear with completions
      writeReg(5'h00, 32'hF, 4'h0);
      writeReg(5'h08, 32'hF, 4'h0);
      pulseDone(4'hF);
      readReg(5'h14, 32'h8, "cnt_plus4");
      writeReg(5'h14, 32'h0, 4'h0);
      for (int k = 0; k < 16383; k++) begin
         writeReg(5'h08, 32'hF, 4'h0);
         pulseDone(4'hF);
      end
      writeReg(5'h08, 32'h3, 4'h0);
      pulseDone(4'h3);
      readReg(5'h14, 32'hFFFE, "cnt_fffe");
      writeReg(5'h08, 32'h1, 4'h0);
      pulseDone(4'h1);
      readReg(5'h14, 32'hFFFF, "cnt_ffff");
      writeReg(5'h08, 32'h3, 4'h0);
      pulseDone(4'h3);
      readReg(5'h14, 32'h1, "cnt_wrap");
      writeReg(5'h08, 32'h3, 4'h0);
      writeReg(5'h14, 32'hFFFF, 4'h3);
      readReg(5'h14, 32'h2, "cnt_clear_count");

      // Abort channel 2
      writeReg(5'h0C, 32'hF00, 4'h0);
      writeReg(5'h00, 32'h4, 4'h0);
      writeReg(5'h08, 32'h4, 4'h0);
      readReg(5'h0C, 32'h4, "busy2");
      writeReg(5'h00, 32'h0, 4'h0);
      readReg(5'h0C, 32'h0, "abort_busy");
      pulseDone(4'h4);
      readReg(5'h0C, 32'h0, "abort_no_done");
      readReg(5'h14, 32'h2, "abort_no_count");

      // Reset mid-run
      writeReg(5'h00, 32'hF, 4'h0);
      writeReg(5'h04, 32'hAB, 4'h0);
      writeReg(5'h10, 32'hF, 4'h0);
      writeReg(5'h08, 32'hF, 4'h0);
      idle();
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      checkOutput("reset_ch_en", 32'(ch_en), 32'h0);
      checkOutput("reset_ch_mode", 32'(ch_mode), 32'h0);
      pulseDone(4'hF);
      for (int off = 0; off < 8; off++) begin
         readReg(5'(off * 4), 32'h0, "reset_read");
      end
      checkOutput("reset_irq", 32'(irq), 32'h0);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         applyStimulus();
      end
      idleCycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
